// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads InstMemory combinationally and
// buffers {pc, inst} pairs in a small FIFO that feeds decode over valid/ready.
// Branch redirects flush the buffer and reload the PC; halt stops new fetches
// while already buffered entries keep draining.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          PC_STEP      = 4,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        fetch_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [31:0]   hold_pc_reg;
  logic [31:0]   hold_inst_reg;
  logic          misalign_reg;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic          not_empty;
  logic          pop;
  logic          fetch;
  logic [CW-1:0] count_next;

  // Handshake and fetch decisions; a redirect masks both push and pop.
  always_comb begin
    not_empty = (count_reg != '0);
    if_valid  = not_empty & ~branch_taken;
    pop       = if_valid & id_ready;
    fetch     = ~halt & ~branch_taken & ((count_reg < CW'(DEPTH)) | pop);
  end

  // Head of the FIFO, or the last value shown once the FIFO is empty.
  always_comb begin
    if (not_empty) begin
      if_pc   = mem_pc[rd_ptr_reg];
      if_inst = mem_inst[rd_ptr_reg];
    end else begin
      if_pc   = hold_pc_reg;
      if_inst = hold_inst_reg;
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_next = count_reg;
    case ({fetch, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Control state: PC, pointers, occupancy, redirect handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= RESET_VECTOR;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      hold_pc_reg   <= '0;
      hold_inst_reg <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      hold_pc_reg   <= if_pc;
      hold_inst_reg <= if_inst;
      if (branch_taken) begin
        pc_reg       <= {branch_target[31:2], 2'b00};
        count_reg    <= '0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        misalign_reg <= (branch_target[1:0] != 2'b00);
      end else begin
        misalign_reg <= 1'b0;
        count_reg    <= count_next;
        if (fetch) begin
          pc_reg     <= pc_reg + 32'(PC_STEP);
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful under count_reg, so no reset.
  always_ff @(posedge clk) begin
    if (fetch) begin
      mem_pc[wr_ptr_reg]   <= pc_reg;
      mem_inst[wr_ptr_reg] <= inst;
    end
  end

  assign pc             = pc_reg;
  assign fetch_misalign = misalign_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_hold_pc;
  logic [31:0] m_hold_inst;
  logic        m_mis;

  always #5 clk = ~clk;

  // instruction memory: word i holds i
  assign inst = pc >> 2;

  inst_fetch_unit #(
    .RESET_VECTOR(32'h0),
    .PC_STEP(4),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .inst(inst),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_valid(if_valid),
    .id_ready(id_ready),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt(halt),
    .fetch_misalign(fetch_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc        = 32'h0;
    m_hold_pc   = 32'h0;
    m_hold_inst = 32'h0;
    m_mis       = 1'b0;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks outputs
  // before any clock edge, then releases it away from an edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_misalign", 32'(fetch_misalign), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance
  // the model across the edge. Entered and left at posedge+1.
  task automatic do_cycle(input logic rdy, input logic br, input logic [31:0] tgt,
                          input logic hlt);
    logic        exp_valid;
    logic [31:0] shown_pc;
    logic [31:0] shown_inst;
    logic        pop;
    logic        fetch;
    id_ready      = rdy;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
    #3;
    exp_valid  = (m_q.size() != 0) && !br;
    shown_pc   = (m_q.size() != 0) ? m_q[0][63:32] : m_hold_pc;
    shown_inst = (m_q.size() != 0) ? m_q[0][31:0]  : m_hold_inst;
    check("pc", pc, m_pc);
    check("if_valid", 32'(if_valid), 32'(exp_valid));
    check("if_pc", if_pc, shown_pc);
    check("if_inst", if_inst, shown_inst);
    check("misalign", 32'(fetch_misalign), 32'(m_mis));
    @(posedge clk);
    m_hold_pc   = shown_pc;
    m_hold_inst = shown_inst;
    if (br) begin
      m_q.delete();
      m_pc  = {tgt[31:2], 2'b00};
      m_mis = (tgt[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      pop   = exp_valid && rdy;
      fetch = !hlt && ((m_q.size() < DEPTH) || pop);
      if (pop) begin
        $display("pop pc=%h inst=%h", shown_pc, shown_inst);
        void'(m_q.pop_front());
      end
      if (fetch) begin
        m_q.push_back({m_pc, m_pc >> 2});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] tgt;
    #1;
    apply_reset();

    // 1: streaming from reset, 1 instr/clk
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("t1_pc", pc, 32'd24);
    check("t1_if_pc", if_pc, 32'd20);
    check("t1_if_inst", if_inst, 32'd5);

    // 2: backpressure from reset, PC freezes at 8 with entries 0,4 buffered
    apply_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_pc_frozen", pc, 32'd8);
    check("t2_if_pc", if_pc, 32'd0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // 3: redirect while full
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h40, 1'b0);
    check("t3_pc", pc, 32'h40);
    do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_if_pc", if_pc, 32'h40);
    check("t3_valid", 32'(if_valid), 32'h1);

    // 4: misaligned target
    do_cycle(1'b1, 1'b1, 32'h42, 1'b0);
    check("t4_pc", pc, 32'h40);
    check("t4_mis_on", 32'(fetch_misalign), 32'h1);
    do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("t4_mis_off", 32'(fetch_misalign), 32'h0);

    // 5: halt drains buffered entries, then PC wrap
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    held_pc = pc;
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_pc_held", pc, held_pc);
    check("t5_drained", 32'(if_valid), 32'h0);
    do_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("t5_pc_top", pc, 32'hFFFF_FFFC);
    do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_wrap", pc, 32'h0);

    // randomized traffic with a mid-stream asynchronous reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      do_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, tgt,
               $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
